// File: rtl/xor_pio_pkg.sv
// rtl/xor_pio_pkg.sv - shared types and constants for the XOR network PIO sequencer
package xor_pio_pkg;

    localparam int              Q_W           = 17;
    localparam logic [Q_W-1:0]  ONE_Q_DEFAULT = 17'h0FFFF;
    localparam logic [Q_W-1:0]  CLASS_THRESH  = 17'h08000;

    localparam logic [9:0]      REG_INPUT     = 10'd0;
    localparam logic [9:0]      REG_CTRL      = 10'd1;
    localparam logic [19:0]     ADDR_X1       = 20'd0;
    localparam logic [19:0]     ADDR_X2       = 20'd1;
    localparam logic [19:0]     ADDR_STATUS   = 20'd0;
    localparam logic [19:0]     ADDR_CLASS    = 20'd1;

    localparam int              ST_VALID      = 0;
    localparam int              ST_BUSY       = 1;
    localparam int              ST_CLASS      = 2;
    localparam int              ST_ERROR      = 8;
    localparam int              ST_ACK        = 31;

    // The capture of y_i happens on the edge that ends the last RUN cycle,
    // so a separate capture state would only add a cycle before the ack.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_RUN    = 2'd2,
        S_ACK    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/xor_pio_sequencer_toggle_hs.sv
// rtl/xor_pio_sequencer_toggle_hs.sv - request/ack toggle handshake (module pio_toggle_hs)
module pio_toggle_hs (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic take,
    input  logic ack_en,
    output logic pending,
    output logic ack
);

    logic seen_q;

    assign pending = (req != seen_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= 1'b0;
            ack    <= 1'b0;
        end else begin
            if (take)
                seen_q <= req;
            if (ack_en)
                ack <= seen_q;
        end
    end

endmodule

// File: rtl/xor_pio_sequencer.sv
// rtl/xor_pio_sequencer.sv - PIO command sequencer for the XOR network (option: XOR_PIO_CLASSIFY_EN)
module xor_pio_sequencer
    import xor_pio_pkg::*;
#(
    parameter int             NET_LATENCY = 6,
    parameter logic [Q_W-1:0] ONE_Q       = ONE_Q_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pp_out_lw_axi,
    input  logic [31:0]      pp_out_axi,
    output logic [31:0]      pp_in_axi,
    output logic [31:0]      pp_in_lw_axi,
    output logic [Q_W-1:0]   x1_o,
    output logic [Q_W-1:0]   x2_o,
    input  logic [Q_W-1:0]   y_i
);

    seq_state_t     state;
    logic           cmd_we;
    logic [9:0]     cmd_reg;
    logic [19:0]    cmd_addr;
    logic [31:0]    cmd_data;
    logic [31:0]    in0_q;
    logic [31:0]    in1_q;
    logic [Q_W-1:0] y_q;
    logic [7:0]     cnt;
    logic           rv_q;
    logic           busy_q;
    logic           err_q;
    logic           cls_bit;
    logic           pending;
    logic           ack;
    logic [31:0]    status;

    pio_toggle_hs u_hs (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (pp_out_lw_axi[31]),
        .take    (state == S_IDLE && pending),
        .ack_en  (state == S_ACK),
        .pending (pending),
        .ack     (ack)
    );

    wire is_x1     = (cmd_reg == REG_INPUT) && (cmd_addr == ADDR_X1);
    wire is_x2     = (cmd_reg == REG_INPUT) && (cmd_addr == ADDR_X2);
    wire is_ctrl   = (cmd_reg == REG_CTRL)  && (cmd_addr == ADDR_STATUS);
`ifdef XOR_PIO_CLASSIFY_EN
    wire is_class  = (cmd_reg == REG_CTRL)  && (cmd_addr == ADDR_CLASS);
    logic cls_q;
    assign cls_bit = cls_q;
`else
    assign cls_bit = 1'b0;
`endif

    assign x1_o = (in0_q == 32'd1) ? ONE_Q : '0;
    assign x2_o = (in1_q == 32'd1) ? ONE_Q : '0;

    always_comb begin
        status           = '0;
        status[ST_ACK]   = ack;
        status[ST_ERROR] = err_q;
        status[ST_CLASS] = cls_bit;
        status[ST_BUSY]  = busy_q;
        status[ST_VALID] = rv_q;
    end
    assign pp_in_lw_axi = status;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_we    <= 1'b0;
            cmd_reg   <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            in0_q     <= '0;
            in1_q     <= '0;
            y_q       <= '0;
            cnt       <= '0;
            rv_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            pp_in_axi <= '0;
`ifdef XOR_PIO_CLASSIFY_EN
            cls_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        cmd_we   <= pp_out_lw_axi[30];
                        cmd_reg  <= pp_out_lw_axi[29:20];
                        cmd_addr <= pp_out_lw_axi[19:0];
                        cmd_data <= pp_out_axi;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_ACK;
                    if (cmd_we) begin
                        if (is_x1)
                            in0_q <= cmd_data;
                        else if (is_x2)
                            in1_q <= cmd_data;
                        else if (is_ctrl) begin
                            if (cmd_data[0]) begin
                                rv_q   <= 1'b0;
                                busy_q <= 1'b1;
                                cnt    <= 8'(NET_LATENCY - 1);
                                state  <= S_RUN;
                            end
                        end else
                            err_q <= 1'b1;
                    end else begin
                        if (is_x1)
                            pp_in_axi <= {15'b0, y_q};
                        else if (is_ctrl) begin
                            pp_in_axi <= status;
                            err_q     <= 1'b0;
                        end
`ifdef XOR_PIO_CLASSIFY_EN
                        else if (is_class)
                            pp_in_axi <= {31'b0, cls_q};
`endif
                        else begin
                            pp_in_axi <= '0;
                            err_q     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == 8'd0) begin
                        y_q    <= y_i;
                        rv_q   <= 1'b1;
                        busy_q <= 1'b0;
`ifdef XOR_PIO_CLASSIFY_EN
                        cls_q  <= (y_i >= CLASS_THRESH);
`endif
                        state  <= S_ACK;
                    end else
                        cnt <= cnt - 8'd1;
                end
                S_ACK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_pio_sequencer.sv
// tb/tb_xor_pio_sequencer.sv - randomized self-checking bench for xor_pio_sequencer
module tb_xor_pio_sequencer;

    localparam int          L   = 6;
    localparam logic [16:0] ONE = 17'h0FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] lw = '0;
    logic [31:0] dat = '0;
    logic [31:0] pp_in_axi;
    logic [31:0] pp_in_lw_axi;
    logic [16:0] x1_o, x2_o;
    logic [16:0] y_drv = '0;

    int checks = 0;
    int errors = 0;

    // transaction-level view of the register map
    logic [31:0] m_in0 = '0, m_in1 = '0;
    logic [16:0] m_y = '0;
    bit          m_rv = 0, m_err = 0, m_cls = 0, req_lvl = 0;

    xor_pio_sequencer #(.NET_LATENCY(L), .ONE_Q(ONE)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pp_out_lw_axi (lw),
        .pp_out_axi    (dat),
        .pp_in_axi     (pp_in_axi),
        .pp_in_lw_axi  (pp_in_lw_axi),
        .x1_o          (x1_o),
        .x2_o          (x2_o),
        .y_i           (y_drv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status(input bit ack_b);
        logic [31:0] s;
        s = '0;
        s[31] = ack_b;
        s[8]  = m_err;
        s[2]  = m_cls;
        s[0]  = m_rv;
        return s;
    endfunction

    function automatic logic [16:0] x_of(input logic [31:0] w);
        return (w == 32'd1) ? ONE : 17'd0;
    endfunction

    task automatic capture_model(input logic [16:0] y);
        m_rv = 1;
        m_y  = y;
`ifdef XOR_PIO_CLASSIFY_EN
        m_cls = (y >= 17'h08000);
`endif
    endtask

    task automatic do_cmd(input bit we, input logic [9:0] rn, input logic [19:0] ad, input logic [31:0] d);
        logic [31:0] exp_rd;
        bit          rd, start, old_ack;
        int          lat, exp_lat;
        old_ack = req_lvl;
        start   = we && rn == 10'd1 && ad == 20'd0 && d[0];
        exp_lat = start ? L + 3 : 3;
        rd      = !we;
        exp_rd  = '0;
        if (we) begin
            if (rn == 10'd0 && ad == 20'd0)      m_in0 = d;
            else if (rn == 10'd0 && ad == 20'd1) m_in1 = d;
            else if (rn == 10'd1 && ad == 20'd0) begin
                if (d[0]) capture_model(y_drv);
            end else m_err = 1;
        end else begin
            if (rn == 10'd0 && ad == 20'd0) exp_rd = {15'b0, m_y};
            else if (rn == 10'd1 && ad == 20'd0) begin
                exp_rd = m_status(old_ack);
                m_err  = 0;
            end
`ifdef XOR_PIO_CLASSIFY_EN
            else if (rn == 10'd1 && ad == 20'd1) exp_rd = {31'b0, m_cls};
`endif
            else begin
                exp_rd = '0;
                m_err  = 1;
            end
        end
        req_lvl = ~req_lvl;
        lw  = {req_lvl, we, rn, ad};
        dat = d;
        lat = 0;
        while (pp_in_lw_axi[31] != req_lvl && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (start && lat == L) begin
                check("busy_in_run", {31'b0, pp_in_lw_axi[1]}, 32'd1);
                check("valid_cleared_in_run", {31'b0, pp_in_lw_axi[0]}, 32'd0);
            end
        end
        check("ack_latency", lat, exp_lat);
        check("status", pp_in_lw_axi, m_status(req_lvl));
        check("x1", {15'b0, x1_o}, {15'b0, x_of(m_in0)});
        check("x2", {15'b0, x2_o}, {15'b0, x_of(m_in1)});
        if (rd) check("rdata", pp_in_axi, exp_rd);
    endtask

    task automatic overlap();
        int  n, first, second;
        bit  prev;
        y_drv   = 17'h12345;
        req_lvl = ~req_lvl;
        lw  = {req_lvl, 1'b1, 10'd1, 20'd0};
        dat = 32'd1;
        n = 0; first = 0; second = 0;
        prev = pp_in_lw_axi[31];
        for (int i = 1; i <= L + 20; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                req_lvl = ~req_lvl;
                lw = {req_lvl, 1'b0, 10'd0, 20'd0};
            end
            if (pp_in_lw_axi[31] != prev) begin
                n++;
                prev = pp_in_lw_axi[31];
                if (n == 1) first = i;
                else if (n == 2) second = i;
            end
        end
        capture_model(17'h12345);
        check("overlap_ack_count", n, 2);
        check("overlap_first_ack", first, L + 3);
        check("overlap_second_ack", second, L + 6);
        check("overlap_rdata", pp_in_axi, {15'b0, 17'h12345});
        check("overlap_status", pp_in_lw_axi, m_status(req_lvl));
    endtask

    task automatic reset_mid_run();
        int lat;
        y_drv   = 17'h1ABCD;
        req_lvl = ~req_lvl;
        lw  = {req_lvl, 1'b1, 10'd1, 20'd0};
        dat = 32'd1;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_reset_busy", {31'b0, pp_in_lw_axi[1]}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_status", pp_in_lw_axi, 32'd0);
        check("rst_rdata", pp_in_axi, 32'd0);
        check("rst_x1", {15'b0, x1_o}, 32'd0);
        check("rst_x2", {15'b0, x2_o}, 32'd0);
        m_in0 = '0; m_in1 = '0; m_y = '0; m_rv = 0; m_err = 0; m_cls = 0;
        req_lvl = 1;
        lw = {1'b1, 1'b0, 10'd1, 20'd0};
        @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        while (pp_in_lw_axi[31] != 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("post_reset_ack_latency", lat, 3);
        check("post_reset_rdata", pp_in_axi, 32'd0);
        check("post_reset_status", pp_in_lw_axi, m_status(1'b1));
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", pp_in_axi, 32'd0);
        check("reset_status", pp_in_lw_axi, 32'd0);
        check("reset_x1", {15'b0, x1_o}, 32'd0);
        check("reset_x2", {15'b0, x2_o}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_cmd(1, 10'd0, 20'd0, 32'd1);
        do_cmd(1, 10'd0, 20'd1, 32'd0);
        y_drv = 17'h0A000;
        do_cmd(1, 10'd1, 20'd0, 32'd1);
        do_cmd(0, 10'd0, 20'd0, 32'd0);
        check("y_readback", pp_in_axi, 32'h0000A000);
        overlap();
        do_cmd(1, 10'd3, 20'd0, 32'd5);
        do_cmd(0, 10'd1, 20'd0, 32'd0);
        check("err_read_set", {31'b0, pp_in_axi[8]}, 32'd1);
        do_cmd(0, 10'd1, 20'd0, 32'd0);
        check("err_read_clear", {31'b0, pp_in_axi[8]}, 32'd0);
        do_cmd(1, 10'd0, 20'd1, 32'h80000001);
        do_cmd(0, 10'd1, 20'd1, 32'd0);
`ifdef XOR_PIO_CLASSIFY_EN
        y_drv = 17'h08000;
        do_cmd(1, 10'd1, 20'd0, 32'd1);
        do_cmd(0, 10'd1, 20'd1, 32'd0);
        check("class_at_threshold", pp_in_axi, 32'd1);
        y_drv = 17'h07FFF;
        do_cmd(1, 10'd1, 20'd0, 32'd1);
        do_cmd(0, 10'd1, 20'd1, 32'd0);
        check("class_below_threshold", pp_in_axi, 32'd0);
`endif
        reset_mid_run();

        for (int i = 0; i < 60; i++) begin
            y_drv = 17'($urandom);
            k = $urandom_range(0, 8);
            case (k)
                0: do_cmd(1, 10'd0, 20'd0, ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom);
                1: do_cmd(1, 10'd0, 20'd1, ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom);
                2: do_cmd(0, 10'd0, 20'd0, $urandom);
                3: do_cmd(0, 10'd1, 20'd0, $urandom);
                4: do_cmd(1, 10'd1, 20'd0, $urandom | 32'd1);
                5: do_cmd(1, 10'd1, 20'd0, $urandom & ~32'd1);
                6: do_cmd(1, 10'($urandom_range(2, 1023)), 20'($urandom), $urandom);
                7: do_cmd(0, 10'd0, 20'($urandom_range(1, 1048575)), $urandom);
                default: do_cmd(0, 10'd1, 20'd1, $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
